// File: rtl/gerador_apostas.sv
// gerador_apostas: bet-playback generator.
// Stores decimal digits in groups of five (one bet per group). On start, it
// replays every complete bet to a downstream checker, one digit at a time.
//
// Ports:
//   clock      - single clock, rising edge
//   reset      - asynchronous, active-low
//   carrega    - load strobe, digito_in is written to the buffer
//   digito_in  - decimal digit to load (0..9)
//   iniciar    - start playback of all complete stored bets
//   numero     - digit presented to the checker
//   insere     - one-cycle strobe, numero valid
//   novo_jogo  - one-cycle strobe opening each bet
//   fim_jogo   - one-cycle strobe closing each bet (numero = 5th digit)
//   fim        - one-cycle strobe after the last bet
//   ocupado    - playback in progress
//   cheio      - buffer full
//   n_apostas  - number of complete bets stored
//   erro       - one-cycle strobe on a rejected load or start
module gerador_apostas #(
    parameter int unsigned MAX_APOSTAS = 4,
    parameter int unsigned GAP         = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic [3:0] digito_in,
    input  logic       iniciar,
    output logic [3:0] numero,
    output logic       insere,
    output logic       novo_jogo,
    output logic       fim_jogo,
    output logic       fim,
    output logic       ocupado,
    output logic       cheio,
    output logic [2:0] n_apostas,
    output logic       erro
);

    localparam int unsigned DEPTH = 5 * MAX_APOSTAS;
    localparam int unsigned AW    = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OCIOSO,
        NOVO,
        ENVIA,
        ESPERA,
        FECHA,
        FIM
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] base_q, base_d;     // buffer index of digit 0 of the current bet
    logic [AW-1:0] rd_idx;
    logic [2:0]    k_q, k_d;
    logic [2:0]    aposta_q, aposta_d;
    logic [2:0]    total_q, total_d;
    logic [2:0]    gap_q, gap_d;
    logic [3:0]    numero_q, numero_d;
    logic          erro_q, erro_d;
    logic          we;
    logic          avanca;

    logic [3:0]    mem [DEPTH];

    assign cheio     = (wp_q == AW'(DEPTH));
    assign n_apostas = 3'(wp_q / AW'(5));

    always_comb begin
        estado_d = estado_q;
        wp_d     = wp_q;
        base_d   = base_q;
        k_d      = k_q;
        aposta_d = aposta_q;
        total_d  = total_q;
        gap_d    = gap_q;
        numero_d = numero_q;
        erro_d   = 1'b0;
        we       = 1'b0;
        avanca   = 1'b0;
        rd_idx   = base_q;

        case (estado_q)
            OCIOSO: begin
                // iniciar has priority; a simultaneous carrega is dropped
                if (iniciar) begin
                    if (n_apostas != 3'd0) begin
                        estado_d = NOVO;
                        total_d  = n_apostas;
                        aposta_d = '0;
                        base_d   = '0;
                        k_d      = '0;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else if (carrega && !cheio) begin
                    if (digito_in <= 4'd9) begin
                        we   = 1'b1;
                        wp_d = wp_q + AW'(1);
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            NOVO: begin
                k_d      = '0;
                estado_d = ENVIA;
                rd_idx   = base_q;
                numero_d = mem[rd_idx];
            end
            ENVIA: begin
                if (GAP == 0) begin
                    avanca = 1'b1;
                end else begin
                    estado_d = ESPERA;
                    gap_d    = '0;
                end
            end
            ESPERA: begin
                if (gap_q == 3'(GAP - 1)) begin
                    avanca = 1'b1;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            FECHA: begin
                if ((aposta_q + 3'd1) == total_q) begin
                    estado_d = FIM;
                end else begin
                    aposta_d = aposta_q + 3'd1;
                    base_d   = base_q + AW'(5);
                    estado_d = NOVO;
                end
            end
            FIM: begin
                wp_d     = '0;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase

        // End of a digit slot, reached from ENVIA (GAP=0) or ESPERA expiry.
        // numero is loaded here so it is already valid in the ENVIA cycle.
        if (avanca) begin
            if (k_q < 3'd4) begin
                k_d      = k_q + 3'd1;
                estado_d = ENVIA;
                rd_idx   = base_q + AW'(k_q) + AW'(1);
                numero_d = mem[rd_idx];
            end else begin
                estado_d = FECHA;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            wp_q     <= '0;
            base_q   <= '0;
            k_q      <= '0;
            aposta_q <= '0;
            total_q  <= '0;
            gap_q    <= '0;
            numero_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            wp_q     <= wp_d;
            base_q   <= base_d;
            k_q      <= k_d;
            aposta_q <= aposta_d;
            total_q  <= total_d;
            gap_q    <= gap_d;
            numero_q <= numero_d;
            erro_q   <= erro_d;
        end
    end

    // Storage is not reset; clearing wp is what empties the buffer.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wp_q] <= digito_in;
        end
    end

    assign numero    = numero_q;
    assign erro      = erro_q;
    assign novo_jogo = (estado_q == NOVO);
    assign insere    = (estado_q == ENVIA);
    assign fim_jogo  = (estado_q == FECHA);
    assign fim       = (estado_q == FIM);
    assign ocupado   = (estado_q != OCIOSO);

endmodule

// File: doc/gerador_apostas.md
GERADOR_APOSTAS -- requirements
Module: gerador_apostas

Interface
REQ-001 Parameter: MAX_APOSTAS, 4, bet buffer capacity in complete 5-digit bets (1..6).
REQ-002 Parameter: GAP, 1, idle cycles after each insere pulse (0..7).
REQ-003 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 Port: carrega  in  1  load strobe; digito_in is written to the buffer this cycle.
REQ-006 Port: digito_in  in  4  decimal digit to load (valid range 0..9).
REQ-007 Port: iniciar  in  1  start playback of all complete stored bets.
REQ-008 Port: numero  out  4  digit presented to the checker.
REQ-009 Port: insere  out  1  one-cycle strobe; numero is valid.
REQ-010 Port: novo_jogo  out  1  one-cycle strobe opening each bet.
REQ-011 Port: fim_jogo  out  1  one-cycle strobe closing each bet; numero holds that bet's 5th digit.
REQ-012 Port: fim  out  1  one-cycle strobe after the last bet of a playback.
REQ-013 Port: ocupado  out  1  playback in progress.
REQ-014 Port: cheio  out  1  buffer holds 5*MAX_APOSTAS digits.
REQ-015 Port: n_apostas  out  3  number of complete bets stored (digits loaded / 5, truncated).
REQ-016 Port: erro  out  1  one-cycle strobe on a rejected load or start.

Function
REQ-017 Buffer: 5*MAX_APOSTAS x 4-bit, write pointer wp; digit k of bet b is stored at index 5b+k.
REQ-018 Load accepted only when ocupado=0, cheio=0, iniciar=0, and digito_in<=9; on acceptance, store at wp and wp+1.
REQ-019 Load with digito_in>9: nothing stored; erro=1 next cycle.
REQ-020 Load while cheio=1 or ocupado=1: ignored silently; no erro.
REQ-021 iniciar accepted in OCIOSO with n_apostas>=1; when carrega and iniciar are both high, iniciar wins and carrega is dropped.
REQ-022 iniciar with n_apostas=0: ignored; erro=1 next cycle.
REQ-023 iniciar while ocupado=1: ignored.
REQ-024 FSM states: OCIOSO, NOVO, ENVIA, ESPERA, FECHA, FIM.
REQ-025 OCIOSO->NOVO on accepted iniciar; latch bets=n_apostas; partial trailing digits are never played.
REQ-026 NOVO: novo_jogo=1 for one cycle; digit index k=0; ->ENVIA.
REQ-027 ENVIA: insere=1 and numero=digit k of the current bet for one cycle; ->ESPERA if GAP>0, otherwise as for ESPERA expiry.
REQ-028 ESPERA: insere=0 and numero held for GAP cycles; on expiry, if k<4 then k+1 and ->ENVIA, else ->FECHA.
REQ-029 FECHA: fim_jogo=1 for one cycle with numero = digit 4; ->NOVO for the next bet, or ->FIM after the last bet.
REQ-030 FIM: fim=1 for one cycle; wp cleared (buffer emptied); ->OCIOSO.
REQ-031 ocupado=1 from NOVO through FIM inclusive.
REQ-032 Cycle count per bet = 1 + 5*(1+GAP) + 1; total for N bets = N*(7+5*GAP) + 1.
REQ-033 At most one of novo_jogo, insere, fim_jogo, fim is high in any cycle.
REQ-034 numero holds its last driven value outside ENVIA, ESPERA, and FECHA.
REQ-035 n_apostas and cheio are combinational from wp.

Reset
REQ-036 reset low: state=OCIOSO, wp=0, k=0, bet index=0.
REQ-037 reset low: numero=0; insere, novo_jogo, fim_jogo, fim, ocupado, and erro = 0.
REQ-038 reset low mid-playback: abort immediately; no fim pulse; buffer contents discarded.
REQ-039 First accepted action is possible on the first rising clock edge after reset returns high.

Verification
REQ-040 GAP=1; load 5,3,8,2,0; iniciar -> novo_jogo at t+1; insere with 5,3,8,2,0 at t+2,4,6,8,10; fim_jogo with numero=0 at t+12; fim at t+13.
REQ-041 Load 12 digits -> n_apostas=2; iniciar -> exactly two bets of 12 cycles each, then fim; digits 11-12 are not played; n_apostas=0 afterwards.
REQ-042 MAX_APOSTAS=4; load 21 digits -> cheio=1 after the 20th; the 21st is ignored with no erro; n_apostas=4.
REQ-043 Load digito_in=12 -> erro pulse, n_apostas unchanged; iniciar with empty buffer -> erro pulse, ocupado stays 0.
REQ-044 Assert reset during the 3rd insere of a bet -> all outputs 0 asynchronously; after release, iniciar -> erro (buffer empty).
REQ-045 carrega and iniciar in the same cycle with one stored bet -> playback starts; the loaded digit is absent; GAP=0 gives an insere pulse on 5 consecutive cycles.
